// File: rtl/dice_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dice_game_ctrl
// Brief    : Craps-style dice game controller. Two cascaded free-running die
//            counters, roll latching on button release, and first-roll /
//            point evaluation driving Win and Lose. TestMode substitutes a
//            scripted sum for the dice.
// Revision : 1.0 - initial release
// ============================================================================
module dice_game_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Rb,
    input  logic             NewGame,
    input  logic             TestMode,
    input  logic [3:0]       SumIn,
    output logic [2:0]       Die1,
    output logic [2:0]       Die2,
    output logic [3:0]       Sum,
    output logic [3:0]       Point,
    output logic [CNT_W-1:0] RollCount,
    output logic             Win,
    output logic             Lose
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ROLL1 = 3'd1,
        S_EVAL1 = 3'd2,
        S_POINT = 3'd3,
        S_ROLL2 = 3'd4,
        S_EVAL2 = 3'd5,
        S_WIN   = 3'd6,
        S_LOSE  = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       die1_q, die1_d;
    logic [2:0]       die2_q, die2_d;
    logic [3:0]       sum_q, sum_d;
    logic [3:0]       point_q, point_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             dice_run;
    logic [3:0]       dice_sum;
    logic [3:0]       roll_sum;
    logic             sum_valid;
    logic [CNT_W-1:0] cnt_inc;

    // Shared roll helpers: live dice sum, the value latched at release,
    // legality of the latched sum and the saturating roll counter.
    always_comb begin
        dice_run  = (state_q == S_IDLE) || (state_q == S_ROLL1) ||
                    (state_q == S_POINT) || (state_q == S_ROLL2);
        dice_sum  = {1'b0, die1_q} + {1'b0, die2_q};
        roll_sum  = TestMode ? SumIn : dice_sum;
        sum_valid = (sum_q >= 4'd2) && (sum_q <= 4'd12);
        cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end

    // Die counters: Die1 steps 1..6 while the button is held in a rolling
    // state; Die2 steps only when Die1 wraps. NewGame leaves them alone.
    always_comb begin
        die1_d = die1_q;
        die2_d = die2_q;
        if (Rb && dice_run) begin
            if (die1_q == 3'd6) begin
                die1_d = 3'd1;
                die2_d = (die2_q == 3'd6) ? 3'd1 : die2_q + 3'd1;
            end else begin
                die1_d = die1_q + 3'd1;
            end
        end
    end

    // Game FSM next-state: latch on release, evaluate one cycle later,
    // NewGame overriding every transition.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        point_d = point_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  if (Rb) state_d = S_ROLL1;
            S_ROLL1: begin
                if (!Rb) begin
                    state_d = S_EVAL1;
                    sum_d   = roll_sum;
                end
            end
            S_EVAL1: begin
                if (!sum_valid) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (sum_q == 4'd7 || sum_q == 4'd11) begin
                        state_d = S_WIN;
                    end else if (sum_q == 4'd2 || sum_q == 4'd3 || sum_q == 4'd12) begin
                        state_d = S_LOSE;
                    end else begin
                        point_d = sum_q;
                        state_d = S_POINT;
                    end
                end
            end
            S_POINT: if (Rb) state_d = S_ROLL2;
            S_ROLL2: begin
                if (!Rb) begin
                    state_d = S_EVAL2;
                    sum_d   = roll_sum;
                end
            end
            S_EVAL2: begin
                state_d = S_POINT;
                if (sum_valid) begin
                    cnt_d = cnt_inc;
                    if (sum_q == point_q) begin
                        state_d = S_WIN;
                    end else if (sum_q == 4'd7) begin
                        state_d = S_LOSE;
                    end
                end
            end
            default: state_d = state_q;
        endcase

        if (NewGame) begin
            state_d = S_IDLE;
            sum_d   = sum_q;
            point_d = 4'd0;
            cnt_d   = '0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            die1_q  <= 3'd1;
            die2_q  <= 3'd1;
            sum_q   <= 4'd0;
            point_q <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            die1_q  <= die1_d;
            die2_q  <= die2_d;
            sum_q   <= sum_d;
            point_q <= point_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Die1      = die1_q;
    assign Die2      = die2_q;
    assign Sum       = sum_q;
    assign Point     = point_q;
    assign RollCount = cnt_q;
    assign Win       = (state_q == S_WIN);
    assign Lose      = (state_q == S_LOSE);

endmodule
`default_nettype wire

// File: tb/tb_dice_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dice_game_ctrl
// Brief    : Directed self-checking bench for dice_game_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dice_game_ctrl;

    logic       CLK;
    logic       Reset_n;
    logic       Rb;
    logic       NewGame;
    logic       TestMode;
    logic [3:0] SumIn;
    logic [2:0] Die1;
    logic [2:0] Die2;
    logic [3:0] Sum;
    logic [3:0] Point;
    logic [7:0] RollCount;
    logic       Win;
    logic       Lose;

    int n_cmp = 0;
    int n_err = 0;

    dice_game_ctrl #(.CNT_W(8)) dut (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .Rb        (Rb),
        .NewGame   (NewGame),
        .TestMode  (TestMode),
        .SumIn     (SumIn),
        .Die1      (Die1),
        .Die2      (Die2),
        .Sum       (Sum),
        .Point     (Point),
        .RollCount (RollCount),
        .Win       (Win),
        .Lose      (Lose)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Press, release and let the evaluation edge pass: three edges in all.
    task automatic roll(input logic [3:0] s);
        SumIn = s;
        Rb    = 1'b1;
        tick(1);
        Rb    = 1'b0;
        tick(2);
    endtask

    task automatic new_game();
        Rb      = 1'b0;
        NewGame = 1'b1;
        tick(1);
        NewGame = 1'b0;
    endtask

    initial begin
        Reset_n  = 1'b0;
        Rb       = 1'b0;
        NewGame  = 1'b0;
        TestMode = 1'b1;
        SumIn    = 4'd0;
        #12;
        chk("rst_die1", 32'(Die1), 32'd1);
        chk("rst_die2", 32'(Die2), 32'd1);
        chk("rst_sum", 32'(Sum), 32'd0);
        chk("rst_point", 32'(Point), 32'd0);
        chk("rst_cnt", 32'(RollCount), 32'd0);
        chk("rst_win", 32'(Win), 32'd0);
        chk("rst_lose", 32'(Lose), 32'd0);
        Reset_n = 1'b1;
        tick(1);

        // Natural 7 on the first roll: Win two edges after release.
        SumIn = 4'd7;
        Rb    = 1'b1;
        tick(1);
        Rb    = 1'b0;
        tick(1);
        chk("t1_sum", 32'(Sum), 32'd7);
        chk("t1_win_early", 32'(Win), 32'd0);
        tick(1);
        chk("t1_win", 32'(Win), 32'd1);
        chk("t1_point", 32'(Point), 32'd0);
        chk("t1_cnt", 32'(RollCount), 32'd1);
        Rb = 1'b1;
        tick(2);
        chk("t1_win_hold", 32'(Win), 32'd1);

        // NewGame clears game state but keeps Sum.
        new_game();
        chk("ng_win", 32'(Win), 32'd0);
        chk("ng_cnt", 32'(RollCount), 32'd0);
        chk("ng_sum", 32'(Sum), 32'd7);

        // Point 4, miss with 6, make the point.
        roll(4'd4);
        chk("t2_point", 32'(Point), 32'd4);
        chk("t2_cnt1", 32'(RollCount), 32'd1);
        roll(4'd6);
        chk("t2_point_keep", 32'(Point), 32'd4);
        chk("t2_nowin", 32'(Win), 32'd0);
        chk("t2_nolose", 32'(Lose), 32'd0);
        roll(4'd4);
        chk("t2_win", 32'(Win), 32'd1);
        chk("t2_cnt3", 32'(RollCount), 32'd3);

        // Seven-out, then craps 12 on a fresh game.
        new_game();
        roll(4'd4);
        roll(4'd7);
        chk("t3_lose", 32'(Lose), 32'd1);
        chk("t3_win", 32'(Win), 32'd0);
        chk("t3_cnt", 32'(RollCount), 32'd2);
        new_game();
        chk("t3_lose_clr", 32'(Lose), 32'd0);
        roll(4'd12);
        chk("t3_lose12", 32'(Lose), 32'd1);
        chk("t3_point12", 32'(Point), 32'd0);

        // Invalid sums are discarded in both evaluation states.
        new_game();
        roll(4'd14);
        chk("t5_sum14", 32'(Sum), 32'd14);
        chk("t5_cnt0", 32'(RollCount), 32'd0);
        chk("t5_point0", 32'(Point), 32'd0);
        roll(4'd5);
        chk("t5_point5", 32'(Point), 32'd5);
        chk("t5_cnt1", 32'(RollCount), 32'd1);
        roll(4'd0);
        chk("t5_inv2_cnt", 32'(RollCount), 32'd1);
        chk("t5_inv2_point", 32'(Point), 32'd5);
        roll(4'd8);
        chk("t5_cnt2", 32'(RollCount), 32'd2);

        // NewGame in ROLL2 with Rb held: to IDLE, then straight to ROLL1.
        Rb = 1'b1;
        tick(1);
        NewGame = 1'b1;
        tick(1);
        chk("t5_ng_point", 32'(Point), 32'd0);
        chk("t5_ng_cnt", 32'(RollCount), 32'd0);
        chk("t5_ng_sum", 32'(Sum), 32'd8);
        NewGame = 1'b0;
        SumIn   = 4'd11;
        tick(1);
        Rb = 1'b0;
        tick(2);
        chk("t5_win11", 32'(Win), 32'd1);
        chk("t5_sum11", 32'(Sum), 32'd11);

        // Asynchronous reset between edges while Win is high.
        #2;
        Reset_n = 1'b0;
        #1;
        chk("t6_win", 32'(Win), 32'd0);
        chk("t6_die1", 32'(Die1), 32'd1);
        chk("t6_die2", 32'(Die2), 32'd1);
        chk("t6_sum", 32'(Sum), 32'd0);
        chk("t6_cnt", 32'(RollCount), 32'd0);
        #1;
        Reset_n = 1'b1;

        // Real dice: 8 held edges give Die1=3, Die2=2, sum 5 becomes the point.
        TestMode = 1'b0;
        SumIn    = 4'd7;
        Rb       = 1'b1;
        tick(8);
        chk("t4_die1", 32'(Die1), 32'd3);
        chk("t4_die2", 32'(Die2), 32'd2);
        Rb = 1'b0;
        tick(1);
        chk("t4_sum", 32'(Sum), 32'd5);
        tick(1);
        chk("t4_point", 32'(Point), 32'd5);
        chk("t4_cnt", 32'(RollCount), 32'd1);
        chk("t4_die1_frozen", 32'(Die1), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
